// File: rtl/roll_index_gen.sv
// roll_index_gen
//   Upstream stage of the start-screen roll. While en_1 is held it steps a
//   6-bit pixel index 0..LAST_IDX, one step every TICK_DIV cycles. Each step
//   is marked by a one-cycle roll_cnt strobe. When the last index has been
//   strobed, the block holds in DONE with roll_done set.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   async active-low reset
//   en_1         in   level-sensitive run request; low returns to IDLE
//   water_index  out  current step index (registered)
//   roll_cnt     out  one-cycle step strobe; water_index stable during it
//   led_pos      out  serpentine {row, col} of water_index (combinational)
//   roll_done    out  sequence complete and held
module roll_index_gen #(
  parameter int          TICK_DIV = 25_000_000,
  parameter int          CNT_W    = 25,
  parameter logic [5:0]  LAST_IDX = 6'd63
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_1,
  output logic [5:0] water_index,
  output logic       roll_cnt,
  output logic [5:0] led_pos,
  output logic       roll_done
);

  typedef enum logic [1:0] {IDLE, RUN, STROBE, DONE} state_t;

  // RUN spends TICK_DIV-1 cycles and STROBE spends one cycle, so the strobe
  // period is TICK_DIV.
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [5:0]       idx_d;
  logic             strobe_d, done_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = water_index;
    strobe_d = 1'b0;
    done_d   = roll_done;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        idx_d  = '0;
        done_d = 1'b0;
        if (en_1) state_d = RUN;
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          strobe_d = 1'b1;
          state_d  = STROBE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      STROBE: begin
        // The index advances only after its strobe has been seen. It stops
        // at LAST_IDX, so it never wraps.
        if (water_index == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = water_index + 6'd1;
          state_d = RUN;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // Dropping the run request overrides everything, including a live strobe.
    if (state_q != IDLE && !en_1) begin
      state_d  = IDLE;
      div_d    = '0;
      idx_d    = '0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      water_index <= '0;
      roll_cnt    <= 1'b0;
      roll_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      water_index <= idx_d;
      roll_cnt    <= strobe_d;
      roll_done   <= done_d;
    end
  end

  // Odd rows run right-to-left. For a 3-bit column, 7 - col is equal to ~col.
  always_comb begin
    led_pos = {water_index[5:3],
               water_index[3] ? ~water_index[2:0] : water_index[2:0]};
  end

endmodule
